// File: rtl/alu_exec_pkg.sv
// Shared definitions for the alu_exec block: op codes, FSM states, flag bit positions.
package alu_exec_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_MOV  = 4'd7,
    OP_LDI  = 4'd8,
    OP_ADDI = 4'd9,
    OP_MUL  = 4'd10,
    OP_CMP  = 4'd11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_MUL    = 3'd3,
    S_WSETUP = 3'd4,
    S_WRITE  = 3'd5
  } state_e;

  // Bit positions inside the 4-bit {Z,N,C,V} flag vector.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Codes 12..15 are not defined.
  function automatic logic op_legal(input logic [3:0] op);
    return op <= 4'(OP_CMP);
  endfunction

  // Everything below CMP produces a register write (MUL included).
  function automatic logic op_writes(input logic [3:0] op);
    return op < 4'(OP_CMP);
  endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU for every op except MUL: result plus {Z,N,C,V}.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        flags
);

  localparam int M = DATA_W - 1;

  logic c;
  logic v;

  // Per-op result, carry/borrow and overflow; shifts use only b[2:0].
  always_comb begin
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (op)
      OP_ADD: begin
        {c, result} = {1'b0, a} + {1'b0, b};
        v = (a[M] == b[M]) && (result[M] != a[M]);
      end
      OP_ADDI: begin
        {c, result} = {1'b0, a} + {1'b0, imm};
        v = (a[M] == imm[M]) && (result[M] != a[M]);
      end
      OP_SUB, OP_CMP: begin
        result = a - b;
        c = a < b;
        v = (a[M] != b[M]) && (result[M] != a[M]);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      // The extra bit catches the last bit shifted out; zero when amount is 0.
      OP_SHL: {c, result} = {1'b0, a} << b[2:0];
      OP_SHR: {result, c} = {a, 1'b0} >> b[2:0];
      OP_MOV: result = a;
      OP_LDI: result = imm;
      default: result = '0;
    endcase
  end

  assign flags = {result == '0, result[M], c, v};

endmodule

// File: rtl/alu_exec.sv
// Multi-cycle ALU executor: instruction handshake, register-file read/write
// sequencing, iterative shift-add multiply and flag register.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [3:0]         instr_op,
  input  logic [RADDR_W-1:0] instr_rd,
  input  logic [RADDR_W-1:0] instr_rs1,
  input  logic [RADDR_W-1:0] instr_rs2,
  input  logic [DATA_W-1:0]  instr_imm,
  output logic [RADDR_W-1:0] rf_sel_o1,
  output logic [RADDR_W-1:0] rf_sel_o2,
  input  logic [DATA_W-1:0]  rf_o1,
  input  logic [DATA_W-1:0]  rf_o2,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_sel_in,
  output logic [DATA_W-1:0]  rf_in,
  output logic [3:0]         flags,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int CNT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);

  state_e state, state_nxt;

  logic [3:0]          op_q;
  logic [RADDR_W-1:0]  rd_q;
  logic [DATA_W-1:0]   imm_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;

  logic [2*DATA_W-1:0] acc;
  logic [2*DATA_W-1:0] acc_nxt;
  logic [2*DATA_W-1:0] mcand;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    mcnt;

  logic [DATA_W-1:0]   core_res;
  logic [3:0]          core_flags;

  alu_core #(.DATA_W(DATA_W)) u_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (core_res),
    .flags  (core_flags)
  );

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nxt = S_READ;
      end
      S_READ:   state_nxt = (op_q == 4'(OP_MUL)) ? S_MUL : S_EXEC;
      S_EXEC: begin
        if (op_writes(op_q)) begin
          state_nxt = S_WSETUP;
        end else begin
          state_nxt = S_IDLE;
          done      = 1'b1;
          illegal   = !op_legal(op_q);
        end
      end
      S_MUL:    if (mcnt == MUL_LAST) state_nxt = S_WSETUP;
      S_WSETUP: state_nxt = S_WRITE;
      S_WRITE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  // Instruction latch, operand capture, multiplier iteration, flags and write port.
  // The write port only moves on the edge entering WSETUP so a latch-based
  // register file sees stable address/data around rf_we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      imm_q     <= '0;
      rf_sel_o1 <= '0;
      rf_sel_o2 <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      mcnt      <= '0;
      flags     <= '0;
      rf_we     <= 1'b0;
      rf_sel_in <= '0;
      rf_in     <= '0;
    end else begin
      rf_we <= (state_nxt == S_WRITE);

      if (instr_valid && instr_ready) begin
        op_q      <= instr_op;
        rd_q      <= instr_rd;
        imm_q     <= instr_imm;
        rf_sel_o1 <= instr_rs1;
        rf_sel_o2 <= instr_rs2;
      end

      if (state == S_READ) begin
        a_q    <= rf_o1;
        b_q    <= rf_o2;
        acc    <= '0;
        mcand  <= {{DATA_W{1'b0}}, rf_o1};
        mplier <= rf_o2;
        mcnt   <= '0;
      end

      if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        mcnt   <= mcnt + 1'b1;
        if (mcnt == MUL_LAST) begin
          rf_sel_in <= rd_q;
          rf_in     <= acc_nxt[DATA_W-1:0];
          flags     <= {acc_nxt[DATA_W-1:0] == '0, acc_nxt[DATA_W-1],
                        |acc_nxt[2*DATA_W-1:DATA_W], 1'b0};
        end
      end

      // Illegal ops leave flags and the write port untouched.
      if (state == S_EXEC && op_legal(op_q)) begin
        flags <= core_flags;
        if (op_writes(op_q)) begin
          rf_sel_in <= rd_q;
          rf_in     <= core_res;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec with a behavioural 16-entry register file.
module tb_alu_exec;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [3:0]    instr_op = '0;
  logic [AW-1:0] instr_rd = '0, instr_rs1 = '0, instr_rs2 = '0;
  logic [DW-1:0] instr_imm = '0;
  logic [AW-1:0] rf_sel_o1, rf_sel_o2, rf_sel_in;
  logic [DW-1:0] rf_o1, rf_o2, rf_in;
  logic          rf_we, busy, done, illegal;
  logic [3:0]    flags;

  always #5 clk = ~clk;

  alu_exec #(.DATA_W(DW), .RADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_rd    (instr_rd),
    .instr_rs1   (instr_rs1),
    .instr_rs2   (instr_rs2),
    .instr_imm   (instr_imm),
    .rf_sel_o1   (rf_sel_o1),
    .rf_sel_o2   (rf_sel_o2),
    .rf_o1       (rf_o1),
    .rf_o2       (rf_o2),
    .rf_we       (rf_we),
    .rf_sel_in   (rf_sel_in),
    .rf_in       (rf_in),
    .flags       (flags),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  // Register file model: combinational reads, write on clock edge.
  logic [DW-1:0] rf [16] = '{default: '0};
  assign rf_o1 = rf[rf_sel_o1];
  assign rf_o2 = rf[rf_sel_o2];
  always @(posedge clk) if (rf_we) rf[rf_sel_in] <= rf_in;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction, then watch 20 cycles. valid is held high with a junk
  // LDI while busy so any accepted-while-busy instruction shows up as an extra write.
  task automatic run(input string tag, input logic [3:0] op, input logic [3:0] rd,
                     input logic [3:0] rs1, input logic [3:0] rs2, input logic [7:0] imm,
                     input int lat, input logic we, input logic [7:0] val,
                     input logic [3:0] flg, input logic ill);
    int done_k = 0;
    int we_n = 0;
    logic ill_s = 1'b0, stab = 1'b1, rdy_after = 1'b0, was_we = 1'b0;
    logic [7:0] prev_in, we_val = '0;
    logic [3:0] prev_sel, we_sel = '0;
    @(negedge clk);
    chk({tag, " ready"}, instr_ready, 1);
    instr_valid = 1'b1; instr_op = op; instr_rd = rd;
    instr_rs1 = rs1; instr_rs2 = rs2; instr_imm = imm;
    @(posedge clk); #1;
    instr_op = 4'd8; instr_rd = 4'd0; instr_rs1 = 4'd0; instr_rs2 = 4'd0; instr_imm = 8'hFF;
    prev_in = rf_in; prev_sel = rf_sel_in;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done && done_k == 0) begin done_k = k; ill_s = illegal; end
      if (done_k != 0 && k == done_k + 1) rdy_after = instr_ready;
      if ((rf_we || was_we) && (rf_in !== prev_in || rf_sel_in !== prev_sel)) stab = 1'b0;
      if (rf_we) begin we_n++; we_sel = rf_sel_in; we_val = rf_in; end
      was_we = rf_we;
      prev_in = rf_in; prev_sel = rf_sel_in;
      instr_valid = busy;
    end
    instr_valid = 1'b0;
    chk({tag, " latency"}, done_k, lat);
    chk({tag, " we_count"}, we_n, we ? 1 : 0);
    if (we) begin
      chk({tag, " rf_sel_in"}, we_sel, rd);
      chk({tag, " rf_in"}, we_val, val);
      chk({tag, " wport_stable"}, stab, 1);
    end
    chk({tag, " flags"}, flags, flg);
    chk({tag, " illegal"}, ill_s, ill);
    chk({tag, " ready_after"}, rdy_after, 1);
  endtask

  initial begin
    int we_seen;
    #2;
    chk("rst busy", busy, 0);
    chk("rst ready", instr_ready, 1);
    chk("rst rf_we", rf_we, 0);
    chk("rst done", done, 0);
    chk("rst flags", flags, 0);
    chk("rst wport", {rf_sel_in, rf_in}, 0);
    chk("rst sel_o", {rf_sel_o1, rf_sel_o2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //   tag         op     rd     rs1    rs2    imm     lat we val    flags  ill
    run("ldi r3",    4'd8,  4'd3,  4'd0,  4'd0,  8'h5A,  4, 1, 8'h5A, 4'b0000, 0);
    run("ldi r1",    4'd8,  4'd1,  4'd0,  4'd0,  8'h7F,  4, 1, 8'h7F, 4'b0000, 0);
    run("ldi r4",    4'd8,  4'd4,  4'd0,  4'd0,  8'h01,  4, 1, 8'h01, 4'b0000, 0);
    run("add ovf",   4'd0,  4'd2,  4'd1,  4'd4,  8'h00,  4, 1, 8'h80, 4'b0101, 0);
    run("ldi r5",    4'd8,  4'd5,  4'd0,  4'd0,  8'h10,  4, 1, 8'h10, 4'b0000, 0);
    run("ldi r6",    4'd8,  4'd6,  4'd0,  4'd0,  8'h20,  4, 1, 8'h20, 4'b0000, 0);
    run("cmp",       4'd11, 4'd0,  4'd5,  4'd6,  8'h00,  2, 0, 8'h00, 4'b0110, 0);
    run("op14",      4'd14, 4'd0,  4'd5,  4'd6,  8'h00,  2, 0, 8'h00, 4'b0110, 1);
    run("ldi r7",    4'd8,  4'd7,  4'd0,  4'd0,  8'h13,  4, 1, 8'h13, 4'b0000, 0);
    run("ldi r8",    4'd8,  4'd8,  4'd0,  4'd0,  8'h11,  4, 1, 8'h11, 4'b0000, 0);
    run("mul",       4'd10, 4'd9,  4'd7,  4'd8,  8'h00, 11, 1, 8'h43, 4'b0010, 0);
    run("sub neg",   4'd1,  4'd10, 4'd5,  4'd6,  8'h00,  4, 1, 8'hF0, 4'b0110, 0);
    run("sub pos",   4'd1,  4'd11, 4'd6,  4'd5,  8'h00,  4, 1, 8'h10, 4'b0000, 0);
    run("ldi r13",   4'd8,  4'd13, 4'd0,  4'd0,  8'h02,  4, 1, 8'h02, 4'b0000, 0);
    run("shl 2",     4'd5,  4'd12, 4'd3,  4'd13, 8'h00,  4, 1, 8'h68, 4'b0010, 0);
    run("shr 2",     4'd6,  4'd12, 4'd3,  4'd13, 8'h00,  4, 1, 8'h16, 4'b0010, 0);
    run("shl 0",     4'd5,  4'd12, 4'd3,  4'd0,  8'h00,  4, 1, 8'h5A, 4'b0000, 0);
    run("addi cy",   4'd9,  4'd14, 4'd1,  4'd0,  8'h81,  4, 1, 8'h00, 4'b1010, 0);
    run("or",        4'd3,  4'd15, 4'd5,  4'd6,  8'h00,  4, 1, 8'h30, 4'b0000, 0);
    run("and",       4'd2,  4'd15, 4'd5,  4'd6,  8'h00,  4, 1, 8'h00, 4'b1000, 0);
    run("mov",       4'd7,  4'd1,  4'd2,  4'd0,  8'h00,  4, 1, 8'h80, 4'b0100, 0);
    run("xor rd=rs", 4'd4,  4'd3,  4'd3,  4'd3,  8'h00,  4, 1, 8'h00, 4'b1000, 0);
    run("sub ovf",   4'd1,  4'd10, 4'd2,  4'd4,  8'h00,  4, 1, 8'h7F, 4'b0001, 0);
    run("mul wrap",  4'd10, 4'd9,  4'd2,  4'd13, 8'h00, 11, 1, 8'h00, 4'b1010, 0);
    run("op12",      4'd12, 4'd0,  4'd0,  4'd0,  8'h00,  2, 0, 8'h00, 4'b1010, 1);

    // Reset during the fifth MUL cycle (cycles 2..9 after transfer are MUL).
    @(negedge clk);
    instr_valid = 1'b1; instr_op = 4'd10; instr_rd = 4'd9; instr_rs1 = 4'd7; instr_rs2 = 4'd8;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst ready", instr_ready, 1);
    chk("midrst rf_we", rf_we, 0);
    chk("midrst done_ill", {done, illegal}, 0);
    chk("midrst flags", flags, 0);
    chk("midrst wport", {rf_sel_in, rf_in}, 0);
    chk("midrst sel_o", {rf_sel_o1, rf_sel_o2}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst ready_release", instr_ready, 1);
    we_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (rf_we) we_seen++;
    end
    chk("midrst no_write", we_seen, 0);
    chk("midrst idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set data width of operands, results and register-file data ports.
REQ-002 Parameter RADDR_W, default 4, SHALL set register-select width (16 registers).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 instr_valid  in  1; instr_ready  out  1  instruction handshake; transfer on valid&&ready at a clk edge.
REQ-006 instr_op  in  4; instr_rd, instr_rs1, instr_rs2  in  RADDR_W; instr_imm  in  DATA_W  instruction fields, sampled only on transfer.
REQ-007 rf_sel_o1, rf_sel_o2  out  RADDR_W; rf_o1, rf_o2  in  DATA_W  register-file read selects and combinational read data.
REQ-008 rf_we  out  1; rf_sel_in  out  RADDR_W; rf_in  out  DATA_W  register-file write port, all registered.
REQ-009 flags  out  4  {Z,N,C,V} bits 3..0; busy  out  1  (not IDLE); done  out  1  one-cycle completion pulse; illegal  out  1  one-cycle pulse.

Function
REQ-010 States SHALL be IDLE, READ, EXEC, MUL, WSETUP, WRITE; instr_ready=1 only in IDLE.
REQ-011 Transfer SHALL latch op/rd/imm, load rf_sel_o1=rs1, rf_sel_o2=rs2, go READ; selects held until next transfer.
REQ-012 At READ exit, rf_o1/rf_o2 SHALL be captured as A/B; next state MUL if op=MUL, else EXEC.
REQ-013 Ops: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 SHL A<<B[2:0]; 6 SHR A>>B[2:0] logical; 7 MOV A; 8 LDI imm; 9 ADDI A+imm; 10 MUL low byte of A*B; 11 CMP A-B flags only; 12-15 illegal.
REQ-014 EXEC SHALL register result and new flags; next WSETUP for write ops, IDLE for CMP/illegal with done=1 during EXEC.
REQ-015 MUL SHALL be iterative shift-add, exactly 8 cycles in MUL, then WSETUP.
REQ-016 WSETUP SHALL load rf_sel_in=rd, rf_in=result; WRITE SHALL assert rf_we and done for exactly one cycle, then IDLE.
REQ-017 rf_sel_in and rf_in SHALL not change while rf_we=1 or in the cycle after; they change only on WSETUP entry (latch-based register file).
REQ-018 Latency: transfer edge to done = 4 cycles (ALU ops), 11 cycles (MUL), 2 cycles (CMP/illegal); next transfer possible the cycle after done.
REQ-019 Flags: Z=(result==0), N=result[DATA_W-1]; ADD/ADDI C=carry-out, V=signed overflow; SUB/CMP C=borrow (A<B unsigned), V=signed overflow; SHL/SHR C=last bit shifted out, 0 if amount 0, V=0; logic/MOV/LDI C=V=0; MUL C=(high byte!=0), V=0.
REQ-020 Illegal op SHALL pulse illegal with done, leave flags and write port unchanged, assert no rf_we.
REQ-021 rd equal to rs1/rs2 SHALL use pre-write operand values; instr_valid while busy SHALL be ignored.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, rf_we=0, done=0, illegal=0, flags=0, rf_sel_in=0, rf_in=0, rf_sel_o1=rf_sel_o2=0, busy=0.
REQ-023 Reset mid-instruction SHALL abandon it with no later write; instr_ready=1 in the first cycle after release.

Structure
REQ-024 Package alu_exec_pkg SHALL hold the op-code enum, state enum and flag bit-index constants.
REQ-025 Combinational sub-module alu_core SHALL compute non-MUL result and flags; MUL iteration and FSM live in alu_exec.

Verification
REQ-026 Reset, LDI rd=3 imm=0x5A -> rf_sel_in=3, rf_in=0x5A stable one cycle before rf_we; rf_we one cycle; flags=0000; done 4 cycles after transfer.
REQ-027 ADD with A=0x7F, B=0x01, rd=2 -> rf_in=0x80, flags Z0 N1 C0 V1.
REQ-028 CMP A=0x10, B=0x20 -> no rf_we, flags Z0 N1 C1 V0, done 2 cycles after transfer.
REQ-029 MUL A=0x13, B=0x11 -> rf_in=0x43, C=1, done 11 cycles after transfer.
REQ-030 op=14 -> illegal and done pulse together, no rf_we, flags unchanged from prior value.
REQ-031 rst_n low in 5th MUL cycle -> all outputs reset immediately, no rf_we after release, instr_ready=1.
